ovc_credit_tracker: RTL
=======================

# ovc_credit_tracker

Per-output-port tracker of output-VC credit and allocation state. It consumes the grants the combined VC/switch allocator produces for one output port: OVC allocations, and flits sent through the crossbar with their tail marks. It also consumes credits returned by the downstream router. From these it produces the registered full, nearly-full, allocated and available vectors that build the allocator's masked OVC requests on the next cycle. One instance sits per output port, between the allocator grant outputs and the OVC request masking logic.

## Interface
Parameters:
- `V`, default 4: VCs per port.
- `B`, default 4: downstream buffer depth per VC, in flits. Must be at least 2.
- `ATOMIC_VC`, default 1:
  - 1: an OVC is available only when it is unallocated and holds all B credits.
  - 0: unallocated and not full is sufficient.
- `CW`, derived as ceil(log2(B+1)): credit counter width.

Ports:
- `clk`, input, 1: clock. The block has one clock.
- `reset`, input, 1: synchronous, active-high reset.
- `credit_in`, input, V: credit returned per VC. Several bits may be high in one cycle.
- `flit_sent`, input, 1: a flit leaves this output port this cycle.
- `flit_sent_ovc`, input, V: one-hot OVC of the sent flit. Valid only when `flit_sent` = 1.
- `flit_sent_tail`, input, 1: the sent flit is a tail or single-flit packet.
- `ovc_allocate`, input, V: one-hot OVC granted to a header this cycle. All zero means no grant.
- `credit_count_all`, output, V*CW: credit count per VC. VC v occupies bits [v*CW +: CW].
- `ovc_full_all`, output, V: count is 0.
- `ovc_nearly_full_all`, output, V: count is 1 or less.
- `ovc_allocated_all`, output, V: the OVC is owned by an in-flight packet.
- `ovc_avail_all`, output, V: the OVC can be granted to a new header.
- `credit_err`, output, 1: sticky protocol-error flag.

## Operation
Credit counter, per VC v:
- Define `send_v` = `flit_sent` & `flit_sent_ovc`[v] and `cred_v` = `credit_in`[v].
- `send_v` & !`cred_v`:
  - If count > 0: count decrements by 1.
  - If count = 0: count holds at 0 and `credit_err` is set (underflow).
- `cred_v` & !`send_v`:
  - If count < B: count increments by 1.
  - If count = B: count holds at B and `credit_err` is set (overflow).
- Both or neither: count holds. This applies even when count is 0 or B; no error is raised.

Allocation bit, per VC v:
- Define `rel_v` = `send_v` & `flit_sent_tail`.
- Next value = (allocated & !`rel_v`) | (`ovc_allocate`[v] & !`rel_v`).
- A single-flit packet allocated and sent in the same cycle therefore leaves the bit at 0.
- A header allocated in the same cycle that another packet's tail releases the same VC also leaves the bit at 0. This is the pass-through case, and the allocator must not issue it for multi-flit packets.
- `ovc_allocate`[v] while allocated[v] = 1 and `rel_v` = 0: set `credit_err`; the bit stays 1.
- `ovc_allocate` with more than one bit set: set `credit_err`; the bits are still applied.
- `rel_v` while allocated[v] = 0 and `ovc_allocate`[v] = 0: set `credit_err`.

Derived outputs, all computed from the registered state:
- `ovc_full_all`[v] = (count_v == 0).
- `ovc_nearly_full_all`[v] = (count_v <= 1).
- `ovc_avail_all`[v]:
  - `ATOMIC_VC` = 1: !allocated_v & (count_v == B).
  - `ATOMIC_VC` = 0: !allocated_v & (count_v != 0).
- `credit_err` is sticky and is cleared only by `reset`.

## Timing
- Every output is a function of registers only; no input-to-output combinational path exists.
- Latency: an input event in cycle k is visible on the outputs in cycle k+1.
- Reset, synchronous and active-high, takes effect at the clock edge where `reset` = 1. Reset values:
  - every count = B (`credit_count_all` holds B in each field);
  - `ovc_full_all` = 0;
  - `ovc_nearly_full_all` = 0;
  - `ovc_allocated_all` = 0;
  - `ovc_avail_all` = all ones;
  - `credit_err` = 0.
- Reset mid-operation discards all in-flight state, including outstanding credits.
- Inputs sampled in a cycle with `reset` = 1 are ignored.

## Test plan
- Reset then idle, V=4, B=4: after reset, every count = 4, `ovc_avail_all` = 4'b1111, `ovc_full_all` = 0, and `credit_err` = 0.
- Multi-flit packet on VC2, stimulus in order:
  1. `ovc_allocate` = 4'b0100;
  2. 3 flits sent on VC2, the last with `flit_sent_tail` = 1.
  - Required response: after step 1, `ovc_allocated_all`[2] = 1 and `ovc_avail_all`[2] = 0. After the tail, `ovc_allocated_all`[2] = 0 and count2 = 1. `ovc_avail_all`[2] stays 0 under `ATOMIC_VC` = 1 until 3 credits return, then becomes 1.
- Drain to empty on VC0: 4 sends with no credits. Required: count0 goes 4, 3, 2, 1, 0; `ovc_nearly_full_all`[0] = 1 at count 1 and at count 0; `ovc_full_all`[0] = 1 at count 0; `credit_err` = 0.
- Simultaneous send and credit on VC1 with count = 0: count1 stays 0 and `credit_err` = 0. A send alone at count 0 then gives `credit_err` = 1 on the next cycle, and the flag persists until `reset`.
- Single-flit pass-through on VC3: `ovc_allocate`[3] = 1, `flit_sent` = 1 to VC3 and `flit_sent_tail` = 1, all in one cycle. Required: `ovc_allocated_all`[3] = 0 and count3 = 3 on the next cycle, with no error.
- Error cases, each in a separate run:
  - `credit_in`[0] asserted at count = B: count stays B and `credit_err` = 1.
  - Double allocation of VC1: `credit_err` = 1 and `ovc_allocated_all`[1] stays 1.

Source files
------------

// File: rtl/ovc_credit_tracker.sv
// Per-output-port OVC credit counters and allocation bits.
// All outputs come straight from registered state, so they feed next-cycle request masking.
module ovc_credit_tracker #(
    parameter int V         = 4,
    parameter int B         = 4,
    parameter bit ATOMIC_VC = 1'b1,
    parameter int CW        = $clog2(B + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [V-1:0]      credit_in,
    input  logic              flit_sent,
    input  logic [V-1:0]      flit_sent_ovc,
    input  logic              flit_sent_tail,
    input  logic [V-1:0]      ovc_allocate,
    output logic [V*CW-1:0]   credit_count_all,
    output logic [V-1:0]      ovc_full_all,
    output logic [V-1:0]      ovc_nearly_full_all,
    output logic [V-1:0]      ovc_allocated_all,
    output logic [V-1:0]      ovc_avail_all,
    output logic              credit_err
);
    localparam logic [CW-1:0] CNT_MAX = CW'(B);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [V-1:0]  VEC_ONE = V'(1);

    logic [V-1:0][CW-1:0] count_q, count_d;
    logic [V-1:0]         alloc_q, alloc_d;
    logic                 err_q, err_d;
    logic [V-1:0]         send, rel;

    always_comb begin
        send    = flit_sent_ovc & {V{flit_sent}};
        rel     = send & {V{flit_sent_tail}};
        count_d = count_q;
        alloc_d = alloc_q;
        err_d   = err_q;
        // More than one grant bit set: flag it but still apply every bit.
        if ((ovc_allocate & (ovc_allocate - VEC_ONE)) != '0)
            err_d = 1'b1;
        for (int unsigned v = 0; v < V; v++) begin
            if (send[v] && !credit_in[v]) begin
                if (count_q[v] == '0)
                    err_d = 1'b1;
                else
                    count_d[v] = count_q[v] - CNT_ONE;
            end else if (credit_in[v] && !send[v]) begin
                if (count_q[v] == CNT_MAX)
                    err_d = 1'b1;
                else
                    count_d[v] = count_q[v] + CNT_ONE;
            end
            if (ovc_allocate[v] && alloc_q[v] && !rel[v])
                err_d = 1'b1;
            if (rel[v] && !alloc_q[v] && !ovc_allocate[v])
                err_d = 1'b1;
            // A tail in the same cycle wins over a new grant (single-flit / pass-through).
            alloc_d[v] = (alloc_q[v] | ovc_allocate[v]) & ~rel[v];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {V{CNT_MAX}};
            alloc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            alloc_q <= alloc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ovc_full_all        = '0;
        ovc_nearly_full_all = '0;
        ovc_avail_all       = '0;
        for (int unsigned v = 0; v < V; v++) begin
            ovc_full_all[v]        = (count_q[v] == '0);
            ovc_nearly_full_all[v] = (count_q[v] <= CNT_ONE);
            if (ATOMIC_VC)
                ovc_avail_all[v] = !alloc_q[v] && (count_q[v] == CNT_MAX);
            else
                ovc_avail_all[v] = !alloc_q[v] && (count_q[v] != '0);
        end
    end

    assign credit_count_all  = count_q;
    assign ovc_allocated_all = alloc_q;
    assign credit_err        = err_q;

endmodule
